pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and control unit that drives the `ctrl` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC write-enable and `multCtrl`. It computes the forwarding selects (busA_sel_d, busB_sel_d, memWrData_sel_d) that ID/EX latches. It sequences load-use stalls, multi-cycle multiply occupancy of EX, branch/jump redirect flushes and the trap halt.

Parameters:
MULT_LAT, 4, total cycles a multiply occupies EX (including the entry cycle); legal range 2..8.
CNT_W, 3, width of the multiply countdown counter; 2^CNT_W must be at least MULT_LAT.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_rs, id_rt  in  5  ID source register numbers
id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
id_is_mult  in  1  ID instruction is a multiply
id_memWr  in  1  ID instruction is a store (rt is store data)
ex_valid, ex_regWr, ex_memRd  in  1  EX stage qualifiers
ex_rd  in  5  EX destination register
mem_valid, mem_regWr  in  1  MEM stage qualifiers
mem_rd  in  5  MEM destination register
ex_redirect  in  1  branch taken / jump / jr resolved in EX
ex_trap  in  1  EX instruction is a trap (inverse of not_trap in EX)
pcWr  out  1  PC register load enable
ifid_ctrl, idex_ctrl, exmem_ctrl, memwb_ctrl  out  2  each one of GO / STALL / FLUSH
multCtrl  out  2  MULT_IDLE / MULT_START / MULT_HOLD / MULT_DONE
busA_sel_d, busB_sel_d, memWrData_sel_d  out  2  each one of FROM_ID / FROM_EX / FROM_MEM
mult_busy  out  1  FSM is in MBUSY

Behaviour:
- FSM states: RUN, MBUSY, MDONE, HALT. The counter cnt is CNT_W bits wide. State and cnt are the only flops; all outputs are combinational from state, cnt and the inputs.
- Reset (rst low, asynchronous): state goes to RUN and cnt to 0. While rst is low, all four ctrl outputs are FLUSH, pcWr=0, multCtrl=MULT_IDLE, all selects are FROM_ID and mult_busy=0.
- Forwarding, evaluated every cycle for rs (giving busA_sel_d) and rt (giving busB_sel_d and memWrData_sel_d):
  - FROM_EX if ex_valid & ex_regWr & ex_rd==src & src!=0;
  - else FROM_MEM if mem_valid & mem_regWr & mem_rd==src & src!=0;
  - else FROM_ID.
  - EX has priority over MEM. A select is forced to FROM_ID when its "uses" bit is 0. memWrData_sel_d is FROM_ID unless id_memWr.
- Load-use: lu = id_valid & ex_valid & ex_memRd & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)). A store's rt data never causes lu, because it is forwarded later through memWrData_sel.
- Priority per cycle: HALT > ex_trap > ex_redirect > MBUSY > lu > mult entry > normal.
  - HALT: pcWr=0, ifid=FLUSH, idex=FLUSH, exmem=GO, memwb=GO. State stays HALT until reset.
  - ex_trap (state RUN or MDONE): same outputs as HALT; next state is HALT.
  - ex_redirect (RUN or MDONE): pcWr=1, ifid=FLUSH, idex=FLUSH, exmem=GO, memwb=GO.
  - lu: pcWr=0, ifid=STALL, idex=FLUSH (inserts a bubble), exmem=GO, memwb=GO.
  - mult entry (RUN/MDONE, id_valid & id_is_mult & !lu): all ctrl GO, pcWr=1; next state MBUSY with cnt=MULT_LAT-2.
  - MBUSY: pcWr=0, ifid=STALL, idex=STALL, exmem=FLUSH, memwb=GO, multCtrl=MULT_HOLD, mult_busy=1. If cnt==0, next state is MDONE; otherwise cnt decrements by 1. ex_redirect and ex_trap are ignored in MBUSY, because EX holds the multiply.
  - MDONE: multCtrl=MULT_DONE. The multiply leaves EX and normal priority rules apply. Next state is RUN, or MBUSY on a back-to-back mult entry.
  - normal: all ctrl GO, pcWr=1, multCtrl=MULT_IDLE.
- multCtrl is MULT_START in the mult-entry cycle, otherwise as stated above.
- Multiply EX occupancy is exactly MULT_LAT cycles: 1 entry cycle + (MULT_LAT-1) MBUSY cycles. The MDONE cycle is the cycle in which the multiply advances.
- Reset asserted during MBUSY returns to RUN immediately; no partial-multiply state survives.

Decomposition:
- constants.vh holds the pipeline-register ctrl encodings GO/STALL/FLUSH and the forwarding encodings FROM_ID/FROM_EX/FROM_MEM.
- constants.vh also gains MULT_IDLE/START/HOLD/DONE and the FSM state codes.
- Sub-module: fwd_sel, a combinational per-source select. It is instantiated twice (rs, rt); memWrData_sel_d is derived from the rt instance.

Test Plan:
1. ex: add $3 regWr; id: sub reads rs=3 -> busA_sel_d=FROM_EX, all ctrl GO, pcWr=1.
2. mem_rd=5 and ex_rd=5, both regWr; id rt=5 -> busB_sel_d=FROM_EX (EX priority). rs=0 matching ex_rd=0 -> FROM_ID.
3. ex: lw $7; id reads $7 -> one cycle of pcWr=0, ifid=STALL, idex=FLUSH. Next cycle (lw now in MEM) -> busA_sel_d=FROM_MEM, all GO. Same lw followed by sw with $7 as rt only -> no stall, memWrData_sel_d=FROM_EX.
4. mult in ID, MULT_LAT=4 -> cycle0 MULT_START/all GO; cycles1-3 MBUSY, idex=STALL, exmem=FLUSH, mult_busy=1; cycle4 MULT_DONE, state RUN after.
5. ex_redirect=1 with lu also true -> pcWr=1, ifid=FLUSH, idex=FLUSH (redirect wins). ex_redirect during MBUSY -> ignored.
6. ex_trap=1 -> HALT; ifid/idex FLUSH and pcWr=0 for 10+ cycles. Reset pulse mid-MBUSY -> outputs FLUSH during reset, state RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard/control unit: pipeline-register ctrl,
// forwarding selects, multiply-unit control and FSM state codes.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    GO    = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_t;

  typedef enum logic [1:0] {
    FROM_ID  = 2'd0,
    FROM_EX  = 2'd1,
    FROM_MEM = 2'd2
  } fwd_t;

  typedef enum logic [1:0] {
    MULT_IDLE  = 2'd0,
    MULT_START = 2'd1,
    MULT_HOLD  = 2'd2,
    MULT_DONE  = 2'd3
  } mult_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MBUSY = 2'd1,
    MDONE = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-source forwarding select, purely combinational; EX result beats MEM result.
// sel_raw ignores the "uses" bit so store data can still be forwarded.
module fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       uses,
  input  logic       ex_valid,
  input  logic       ex_regWr,
  input  logic [4:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_regWr,
  input  logic [4:0] mem_rd,
  output fwd_t       sel_raw,
  output fwd_t       sel
);

  logic src_nz;
  logic hit_ex;
  logic hit_mem;

  assign src_nz  = (src != 5'd0);
  assign hit_ex  = ex_valid  & ex_regWr  & (ex_rd  == src) & src_nz;
  assign hit_mem = mem_valid & mem_regWr & (mem_rd == src) & src_nz;

  always_comb begin
    sel_raw = FROM_ID;
    if (hit_ex)
      sel_raw = FROM_EX;
    else if (hit_mem)
      sel_raw = FROM_MEM;
  end

  assign sel = uses ? sel_raw : FROM_ID;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/control unit: forwarding selects, load-use stall, multi-cycle
// multiply occupancy of EX, redirect flush and trap halt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_mult,
  input  logic       id_memWr,
  input  logic       ex_valid,
  input  logic       ex_regWr,
  input  logic       ex_memRd,
  input  logic [4:0] ex_rd,
  input  logic       mem_valid,
  input  logic       mem_regWr,
  input  logic [4:0] mem_rd,
  input  logic       ex_redirect,
  input  logic       ex_trap,
  output logic       pcWr,
  output logic [1:0] ifid_ctrl,
  output logic [1:0] idex_ctrl,
  output logic [1:0] exmem_ctrl,
  output logic [1:0] memwb_ctrl,
  output logic [1:0] multCtrl,
  output logic [1:0] busA_sel_d,
  output logic [1:0] busB_sel_d,
  output logic [1:0] memWrData_sel_d,
  output logic       mult_busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  fwd_t rs_raw, rs_sel, rt_raw, rt_sel;
  logic lu;

  fwd_sel u_fwd_rs (
    .src      (id_rs),
    .uses     (id_uses_rs),
    .ex_valid (ex_valid),
    .ex_regWr (ex_regWr),
    .ex_rd    (ex_rd),
    .mem_valid(mem_valid),
    .mem_regWr(mem_regWr),
    .mem_rd   (mem_rd),
    .sel_raw  (rs_raw),
    .sel      (rs_sel)
  );

  fwd_sel u_fwd_rt (
    .src      (id_rt),
    .uses     (id_uses_rt),
    .ex_valid (ex_valid),
    .ex_regWr (ex_regWr),
    .ex_rd    (ex_rd),
    .mem_valid(mem_valid),
    .mem_regWr(mem_regWr),
    .mem_rd   (mem_rd),
    .sel_raw  (rt_raw),
    .sel      (rt_sel)
  );

  // Store data on rt is picked up later via memWrData_sel, so it never stalls.
  assign lu = id_valid & ex_valid & ex_memRd & (ex_rd != 5'd0) &
              ((id_uses_rs & (ex_rd == id_rs)) |
               (id_uses_rt & ~id_memWr & (ex_rd == id_rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    pcWr            = 1'b1;
    ifid_ctrl       = GO;
    idex_ctrl       = GO;
    exmem_ctrl      = GO;
    memwb_ctrl      = GO;
    multCtrl        = MULT_IDLE;
    mult_busy       = 1'b0;
    busA_sel_d      = rs_sel;
    busB_sel_d      = rt_sel;
    memWrData_sel_d = id_memWr ? rt_raw : FROM_ID;

    if (!rst) begin
      pcWr            = 1'b0;
      ifid_ctrl       = FLUSH;
      idex_ctrl       = FLUSH;
      exmem_ctrl      = FLUSH;
      memwb_ctrl      = FLUSH;
      busA_sel_d      = FROM_ID;
      busB_sel_d      = FROM_ID;
      memWrData_sel_d = FROM_ID;
    end else begin
      case (state)
        HALT: begin
          pcWr      = 1'b0;
          ifid_ctrl = FLUSH;
          idex_ctrl = FLUSH;
        end
        // EX holds the multiply: redirect/trap cannot be acted on yet.
        MBUSY: begin
          pcWr       = 1'b0;
          ifid_ctrl  = STALL;
          idex_ctrl  = STALL;
          exmem_ctrl = FLUSH;
          multCtrl   = MULT_HOLD;
          mult_busy  = 1'b1;
          if (cnt == '0)
            state_nxt = MDONE;
          else
            cnt_nxt = cnt - CNT_W'(1);
        end
        default: begin
          state_nxt = RUN;
          if (state == MDONE)
            multCtrl = MULT_DONE;
          if (ex_trap) begin
            pcWr      = 1'b0;
            ifid_ctrl = FLUSH;
            idex_ctrl = FLUSH;
            state_nxt = HALT;
          end else if (ex_redirect) begin
            ifid_ctrl = FLUSH;
            idex_ctrl = FLUSH;
          end else if (lu) begin
            pcWr      = 1'b0;
            ifid_ctrl = STALL;
            idex_ctrl = FLUSH;
          end else if (id_valid & id_is_mult) begin
            multCtrl  = MULT_START;
            state_nxt = MBUSY;
            cnt_nxt   = CNT_W'(MULT_LAT - 2);
          end
        end
      endcase
    end
  end

endmodule
